dap_sram_arbiter: RTL and testbench

//  Shares one port of the 16x8 dual-port coefficient/delay SRAM between two requesters.

---
 rtl/dap_sram_arbiter_pkg.sv | 18 +
 rtl/dap_sram_arbiter_if.sv | 39 +++
 rtl/dap_sram_arbiter_rr_arb2.sv | 36 +++
 rtl/dap_sram_arbiter.sv | 125 ++++++++++++
 tb/tb_dap_sram_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dap_sram_arbiter_pkg.sv
// rtl/dap_sram_arbiter_pkg.sv - shared widths, FSM and arbiter side encodings for the SRAM arbiter
package dap_sram_pkg;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

endpackage

// File: rtl/dap_sram_arbiter_if.sv
// rtl/dap_sram_arbiter_if.sv - requester A/B, read return and clear-control bundle
interface dap_sram_arbiter_if;
    import dap_sram_pkg::*;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;

    logic [DW-1:0] rdata;

    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output clr_start,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, clr_busy, clr_done
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  clr_start,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, clr_busy, clr_done
    );

endinterface

// File: rtl/dap_sram_arbiter_rr_arb2.sv
// rtl/dap_sram_arbiter_rr_arb2.sv - 2-way round-robin arbiter; DAP_ARB_PRIO_B_EN selects fixed B priority
module dap_rr_arb2
    import dap_sram_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    side_t r_ptr;
    logic  w_flip;

`ifdef DAP_ARB_PRIO_B_EN
    // B always wins; the pointer is never advanced
    assign o_gnt[1] = i_accept & i_req[1];
    assign o_gnt[0] = i_accept & i_req[0] & ~i_req[1];
    assign w_flip   = 1'b0;
`else
    // On a conflict the pointer side wins; a lone requester always wins
    assign o_gnt[0] = i_accept & i_req[0] & (~i_req[1] | (r_ptr == SIDE_A));
    assign o_gnt[1] = i_accept & i_req[1] & (~i_req[0] | (r_ptr == SIDE_B));
    assign w_flip   = i_accept & i_req[0] & i_req[1];
`endif

    // Hand the pointer to the losing side after each granted conflict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= SIDE_A;
        end else if (w_flip) begin
            r_ptr <= (r_ptr == SIDE_A) ? SIDE_B : SIDE_A;
        end
    end

endmodule

// File: rtl/dap_sram_arbiter.sv
// rtl/dap_sram_arbiter.sv - single SRAM port shared by host (A) and filter (B) with zero-fill; DAP_ARB_PRIO_B_EN selects fixed B priority
module dap_sram_arbiter
    import dap_sram_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    dap_sram_arbiter_if.slave   bus,
    output logic                sram_csb,
    output logic                sram_oeb,
    output logic                sram_web,
    output logic [AW-1:0]       sram_addr,
    output logic [DW-1:0]       sram_din,
    input  logic [DW-1:0]       sram_dout
);

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_csb;
    logic          r_oeb;
    logic          r_web;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    logic          r_pend_a;
    logic          r_pend_b;
    logic          r_rvalid_a;
    logic          r_rvalid_b;

    logic          w_accept;
    logic [1:0]    w_gnt;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // A clear request takes the cycle, so no grant is offered alongside it
    assign w_accept = (r_state == ST_IDLE) & ~bus.clr_start;

    dap_rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    ({bus.b_req, bus.a_req}),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    assign w_we    = w_gnt[1] ? bus.b_we    : bus.a_we;
    assign w_addr  = w_gnt[1] ? bus.b_addr  : bus.a_addr;
    assign w_wdata = w_gnt[1] ? bus.b_wdata : bus.a_wdata;

    assign bus.a_gnt    = w_gnt[0];
    assign bus.b_gnt    = w_gnt[1];
    assign bus.a_rvalid = r_rvalid_a;
    assign bus.b_rvalid = r_rvalid_b;
    assign bus.rdata    = sram_dout;
    assign bus.clr_busy = r_busy;
    assign bus.clr_done = r_done;

    assign sram_csb  = r_csb;
    assign sram_oeb  = r_oeb;
    assign sram_web  = r_web;
    assign sram_addr = r_addr;
    assign sram_din  = r_din;

    // IDLE/CLEAR sequencer with registered SRAM strobes and a two-stage read-return tag pipe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_csb      <= 1'b1;
            r_oeb      <= 1'b1;
            r_web      <= 1'b1;
            r_addr     <= '0;
            r_din      <= '0;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_csb      <= 1'b1;
            r_oeb      <= 1'b1;
            r_web      <= 1'b1;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            // Reads issued before a clear still drain through here
            r_rvalid_a <= r_pend_a;
            r_rvalid_b <= r_pend_b;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (|w_gnt) begin
                        r_csb    <= 1'b0;
                        r_oeb    <= w_we;
                        r_web    <= ~w_we;
                        r_addr   <= w_addr;
                        r_din    <= w_wdata;
                        r_pend_a <= w_gnt[0] & ~w_we;
                        r_pend_b <= w_gnt[1] & ~w_we;
                    end
                end
                ST_CLEAR: begin
                    r_csb  <= 1'b0;
                    r_web  <= 1'b0;
                    r_addr <= r_cnt;
                    r_din  <= '0;
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dap_sram_arbiter.sv
// tb/tb_dap_sram_arbiter.sv - scoreboard bench for dap_sram_arbiter with a behavioural SRAM
module tb_dap_sram_arbiter;

    logic       clk;
    logic       reset_n;
    logic       sram_csb;
    logic       sram_oeb;
    logic       sram_web;
    logic [3:0] sram_addr;
    logic [7:0] sram_din;
    logic [7:0] sram_dout;
    logic [7:0] mem [16];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    typedef struct {
        bit         side;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t exp_q[$];

    dap_sram_arbiter_if bus ();

    dap_sram_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .sram_csb  (sram_csb),
        .sram_oeb  (sram_oeb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM with registered read data; contents survive reset
    always @(posedge clk) begin
        if (sram_csb === 1'b0) begin
            if (sram_web === 1'b0) mem[sram_addr] <= sram_din;
            else if (sram_oeb === 1'b0) sram_dout <= mem[sram_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    function automatic void push_exp(input bit side, input logic [7:0] data);
        exp_t e;
        e.side = side;
        e.data = data;
        e.due  = cyc + 2;
        exp_q.push_back(e);
    endfunction

    // Read-return monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && (bus.a_rvalid === 1'b1 || bus.b_rvalid === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_side", {bus.a_rvalid, bus.b_rvalid}, e.side ? 2'b01 : 2'b10);
                    check("rdata", bus.rdata, e.data);
                    check("read_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_gnt(input bit side, input bit we, input logic [7:0] exp, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((side ? bus.b_gnt : bus.a_gnt) === 1'b1) begin
                got = 1'b1;
                if (!we) push_exp(side, exp);
            end
        end
        check({nm, "_grant"}, got, 1);
    endtask

    task automatic issue(input bit side, input bit we, input logic [3:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp, input string nm);
        if (side) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
        wait_gnt(side, we, exp, nm);
        @(posedge clk); #1;
        if (side) bus.b_req = 1'b0;
        else      bus.a_req = 1'b0;
    endtask

    initial begin
        bit exp_b;
        reset_n = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.clr_start = 1'b0;

        // 1: asynchronous reset before any clock edge
        #3 reset_n = 1'b0;
        #1;
        check("rst_a_gnt",    bus.a_gnt,    0);
        check("rst_b_gnt",    bus.b_gnt,    0);
        check("rst_a_rvalid", bus.a_rvalid, 0);
        check("rst_b_rvalid", bus.b_rvalid, 0);
        check("rst_clr_busy", bus.clr_busy, 0);
        check("rst_clr_done", bus.clr_done, 0);
        check("rst_csb",      sram_csb,     1);
        check("rst_oeb",      sram_oeb,     1);
        check("rst_web",      sram_web,     1);
        check("rst_addr",     sram_addr,    0);
        check("rst_din",      sram_din,     0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // 2: write then back-to-back read of the same word from the other side
        issue(0, 1, 4'd3, 8'h5A, 8'h00, "t2_a_wr3");
        issue(1, 0, 4'd3, 8'h00, 8'h5A, "t2_b_rd3");
        issue(1, 1, 4'd9, 8'hC3, 8'h00, "t2_b_wr9");
        issue(0, 0, 4'd9, 8'h00, 8'hC3, "t2_a_rd9");
        repeat (3) @(posedge clk); #1;

        // 3 / 6: both sides hold read requests
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd3;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef DAP_ARB_PRIO_B_EN
            exp_b = 1'b1;
`else
            exp_b = (i % 2) == 1;
`endif
            check("t3_a_gnt", bus.a_gnt, !exp_b);
            check("t3_b_gnt", bus.b_gnt, exp_b);
            push_exp(exp_b, exp_b ? 8'hC3 : 8'h5A);
            @(posedge clk); #1;
        end
        bus.b_req = 1'b0;
        wait_gnt(0, 0, 8'h5A, "t3_a_after_b_drop");
        @(posedge clk); #1;
        bus.a_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 4: clear with B requesting throughout
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd15;
        bus.clr_start = 1'b1;
        @(negedge clk);
        check("t4_no_gnt_on_clr_start", bus.b_gnt, 0);
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("t4_busy",   bus.clr_busy, 1);
            check("t4_b_gnt",  bus.b_gnt,    0);
            check("t4_done",   bus.clr_done, 0);
            if (k >= 2) begin
                check("t4_csb",  sram_csb,  0);
                check("t4_web",  sram_web,  0);
                check("t4_addr", sram_addr, k - 2);
                check("t4_din",  sram_din,  0);
            end
        end
        wait_gnt(1, 0, 8'h00, "t4_b_rd15");
        check("t4_done_pulse",  bus.clr_done, 1);
        check("t4_busy_drop",   bus.clr_busy, 0);
        check("t4_last_addr",   sram_addr,    15);
        check("t4_last_web",    sram_web,     0);
        @(posedge clk); #1;
        bus.b_req = 1'b0;
        @(negedge clk);
        check("t4_done_one_cycle", bus.clr_done, 0);
        repeat (3) @(posedge clk); #1;

        // 5: reset in the middle of a clear
        issue(0, 1, 4'd8, 8'hA5, 8'h00, "t5_a_wr8");
        bus.clr_start = 1'b1;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t5_busy_before_rst", bus.clr_busy, 1);
        reset_n = 1'b0;
        #1;
        check("t5_busy_async", bus.clr_busy, 0);
        check("t5_done_async", bus.clr_done, 0);
        check("t5_csb_async",  sram_csb,     1);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_done", bus.clr_done, 0);
        end
        @(posedge clk); #1;
        issue(0, 0, 4'd8, 8'h00, 8'hA5, "t5_a_rd8");
        issue(1, 0, 4'd0, 8'h00, 8'h00, "t5_b_rd0");

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
